pwm_output_driver: RTL and testbench
====================================

// Module: pwm_output_driver
// PURPOSE
//  Consumes the five configuration registers written over SPI (output enables, PWM enables, duty cycle).
//  Drives the 16 chip outputs as static levels or as a shared 8-bit PWM waveform.
//  Sits directly downstream of the SPI register peripheral in the same clk domain.
//  Duty updates are shadowed to the period boundary so a write never truncates or glitches a period.
// PARAMETERS
//  PRESCALE   13  clk cycles per PWM count; 10 MHz/(13*256) = ~3.0 kHz. Must be >=1 (elaboration error otherwise).
//  DUTY_SYNC  1   1: duty shadow loads only at period start; 0: shadow tracks pwm_duty_cycle every clk.
// PORTS
//  clk              in   1   system clock
//  rst_n            in   1   asynchronous active-low reset
//  en_reg_out_7_0   in   8   output enable, channels 7..0
//  en_reg_out_15_8  in   8   output enable, channels 15..8
//  en_reg_pwm_7_0   in   8   PWM-mode select, channels 7..0
//  en_reg_pwm_15_8  in   8   PWM-mode select, channels 15..8
//  pwm_duty_cycle   in   8   requested duty, 0x00 = 0%, 0xFF = 100%
//  out              out  16  channel outputs, registered
//  period_start     out  1   one-clk pulse in the first cycle of each PWM period
// BEHAVIOUR
//  - Reset: rst_n is asynchronous and active-low; clock is clk. All config inputs are synchronous to clk, so no synchronisers are needed.
//  - Reset values: out = 16'h0000, period_start = 0, pre_cnt = 0, pwm_cnt = 0, duty_shadow = 0.
//  - Prescaler: pre_cnt counts 0..PRESCALE-1 and wraps.
//    - tick = (pre_cnt == PRESCALE-1).
//    - With PRESCALE = 1, tick is asserted every clk.
//  - Period counter: pwm_cnt[7:0] increments on tick and wraps 255 -> 0. Period = 256*PRESCALE clk (3328 at default).
//  - Period boundary: wrap = tick & (pwm_cnt == 255).
//    - On wrap, period_start is registered to 1, so it is high in the cycle pwm_cnt reads 0. It is 0 otherwise.
//    - The first period after reset has no period_start pulse.
//  - Duty shadow:
//    - DUTY_SYNC = 1: duty_shadow <= pwm_duty_cycle on wrap only. The value sampled is the one present in that same cycle.
//    - DUTY_SYNC = 0: duty_shadow <= pwm_duty_cycle every clk.
//    - After reset, the first period runs at duty 0 when DUTY_SYNC = 1.
//  - PWM level: pwm_level = (duty_shadow == 8'hFF) | (pwm_cnt < duty_shadow).
//    - Duty d in 1..254 gives d*PRESCALE clk high per period.
//    - Duty 0 gives constant low; duty 0xFF gives constant high with no dip at wrap.
//  - Output, per channel i: out[i] <= en_out[i] & (~en_pwm[i] | pwm_level).
//    - en_out = {en_reg_out_15_8, en_reg_out_7_0}; en_pwm is formed the same way.
//    - Enable changes take effect exactly 1 clk later, mid-period, without waiting for the boundary.
//    - en_out = 0 forces the output low regardless of en_pwm.
//    - en_out = 1 with en_pwm = 0 gives a static high.
//  - Latency: out lags pwm_cnt/duty_shadow by 1 clk. The rising edge of each PWM period is on out 1 clk after period_start.
//  - Simultaneous events: a duty change in the same clk as wrap is taken for the new period. An enable change in the same clk as wrap uses the new enable from the next clk.
//  - Reset mid-operation: all state and outputs clear immediately (async). Counting restarts from pre_cnt = 0, pwm_cnt = 0 on the first clk after release.
// STRUCTURE
//  - Shared package pwm_pkg:
//    - PWM_CNT_W = 8, NUM_CH = 16, DUTY_FULL = 8'hFF.
//    - Register address constants 0x00..0x04, shared with the SPI peripheral.
//  - Sub-module pwm_timebase (PRESCALE): owns pre_cnt and pwm_cnt. Outputs pwm_cnt[7:0], tick and wrap.
//  - Top level holds duty_shadow, the period_start register, the compare logic and the 16 output flops.
// TESTING
//  1. Reset: hold rst_n = 0 with all inputs 0xFF.
//     -> out = 0x0000 and period_start = 0 throughout reset; release and check counters start from 0.
//  2. Static: en_out = 0x0001, en_pwm = 0x0000.
//     -> out = 0x0001 exactly 1 clk after the input change. Set en_out = 0x8000 -> out = 0x8000 1 clk later.
//  3. 50% PWM: en_out = en_pwm = 0xFFFF, duty = 0x80, PRESCALE = 13.
//     -> all 16 outputs high for 1664 clk and low for 1664 clk; period_start spacing = 3328 clk.
//  4. Extremes: duty = 0x00 -> out stays 0x0000 for 2 full periods. duty = 0xFF -> out stays 0xFFFF across wrap, no 1-clk dip.
//  5. Shadowing (DUTY_SYNC = 1): change duty 0x40 -> 0xC0 mid-period (pwm_cnt = 0x20).
//     -> the current period stays high for 832 clk total; the next period is high for 2496 clk.
//  6. Mixed and reset mid-period: en_out = 0xFFFF, en_pwm = 0x00FF, duty = 0x40.
//     -> out[15:8] static high and out[7:0] PWM.
//     -> pulse rst_n low at pwm_cnt = 0x10: out = 0x0000 asynchronously; after release, high phase restarts from count 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM output driver and the SPI register block.
// Register addresses must stay in step with the SPI peripheral's decoder.
package pwm_pkg;

  localparam int unsigned PWM_CNT_W = 8;
  localparam int unsigned NUM_CH    = 16;

  localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;

  localparam logic [7:0] ADDR_EN_OUT_7_0  = 8'h00;
  localparam logic [7:0] ADDR_EN_OUT_15_8 = 8'h01;
  localparam logic [7:0] ADDR_EN_PWM_7_0  = 8'h02;
  localparam logic [7:0] ADDR_EN_PWM_15_8 = 8'h03;
  localparam logic [7:0] ADDR_PWM_DUTY    = 8'h04;

  typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;
  typedef logic [NUM_CH-1:0]    ch_mask_t;

  // Full-scale duty is special-cased so 0xFF stays high through count 255 and across the wrap.
  function automatic logic pwm_compare(input pwm_cnt_t cnt, input pwm_cnt_t duty);
    return (duty == DUTY_FULL) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaler plus 8-bit period counter.
// tick marks the last prescaler cycle of a count; wrap marks the last cycle of a period.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE = 13
) (
  input  logic     clk,
  input  logic     rst_n,
  output pwm_cnt_t pwm_cnt,
  output logic     tick,
  output logic     wrap
);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("pwm_timebase: PRESCALE must be >= 1");
  end

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
  localparam pwm_cnt_t CNT_MAX = '1;

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  pwm_cnt_t         pwm_cnt_q, pwm_cnt_d;

  // With PRESCALE = 1 the prescaler is a constant 0 and tick is high every cycle.
  assign tick = (pre_cnt_q == PRE_MAX);
  assign wrap = tick & (pwm_cnt_q == CNT_MAX);

  always_comb begin
    pre_cnt_d = pre_cnt_q + PRE_W'(1);
    pwm_cnt_d = pwm_cnt_q;
    if (tick) begin
      pre_cnt_d = '0;
      pwm_cnt_d = pwm_cnt_q + PWM_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
      pwm_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  assign pwm_cnt = pwm_cnt_q;

endmodule

// File: rtl/pwm_output_driver.sv
// Drives 16 chip outputs as static levels or a shared 8-bit PWM waveform.
// Duty is shadowed to the period boundary so register writes never cut a period short.
module pwm_output_driver
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE  = 13,
  parameter bit          DUTY_SYNC = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           en_reg_out_7_0,
  input  logic [7:0]           en_reg_out_15_8,
  input  logic [7:0]           en_reg_pwm_7_0,
  input  logic [7:0]           en_reg_pwm_15_8,
  input  logic [PWM_CNT_W-1:0] pwm_duty_cycle,
  output logic [NUM_CH-1:0]    out,
  output logic                 period_start
);

  ch_mask_t en_out, en_pwm;
  pwm_cnt_t pwm_cnt;
  logic     tick, wrap;
  logic     unused_tick;

  pwm_cnt_t duty_shadow_q, duty_shadow_d;
  logic     period_start_q;
  ch_mask_t out_q, out_d;
  logic     pwm_level;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  pwm_timebase #(
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk     (clk),
    .rst_n   (rst_n),
    .pwm_cnt (pwm_cnt),
    .tick    (tick),
    .wrap    (wrap)
  );

  // Only wrap is needed here; tick is kept on the timebase for other consumers.
  assign unused_tick = tick;

  always_comb begin
    duty_shadow_d = duty_shadow_q;
    if (!DUTY_SYNC || wrap) begin
      duty_shadow_d = pwm_duty_cycle;
    end
  end

  assign pwm_level = pwm_compare(pwm_cnt, duty_shadow_q);

  // Enables act on the next clock; only the PWM level is period-aligned.
  always_comb begin
    out_d = en_out & (~en_pwm | {NUM_CH{pwm_level}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow_q  <= '0;
      period_start_q <= 1'b0;
      out_q          <= '0;
    end else begin
      duty_shadow_q  <= duty_shadow_d;
      period_start_q <= wrap;
      out_q          <= out_d;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_output_driver.sv
// Self-checking bench for pwm_output_driver: directed scenarios plus randomized traffic
// compared against a cycle-count based reference model.
module tb_pwm_output_driver;

  localparam int unsigned P   = 13;
  localparam int unsigned PER = 256 * P;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] en_out, en_pwm;
  logic [7:0]  duty;
  logic [15:0] out;
  logic        period_start;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pwm_output_driver #(
    .PRESCALE  (P),
    .DUTY_SYNC (1'b1)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_out[7:0]),
    .en_reg_out_15_8 (en_out[15:8]),
    .en_reg_pwm_7_0  (en_pwm[7:0]),
    .en_reg_pwm_15_8 (en_pwm[15:8]),
    .pwm_duty_cycle  (duty),
    .out             (out),
    .period_start    (period_start)
  );

  // Reference model: n clocks after reset release, the count is (n / P) % 256 and a period
  // boundary falls on every PER-th clock; duty is sampled on those boundary clocks only.
  int unsigned m_cyc;
  logic [7:0]  m_shadow;
  logic [15:0] m_out;
  logic        m_ps;

  function automatic logic [15:0] exp_out(input int unsigned n, input logic [7:0] sh,
                                          input logic [15:0] eo, input logic [15:0] ep);
    int unsigned cnt;
    logic        lvl;
    cnt = (n / P) % 256;
    lvl = (sh == 8'hFF) || (cnt < int'(sh));
    return eo & (~ep | {16{lvl}});
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc    <= 0;
      m_shadow <= 8'h00;
      m_out    <= 16'h0000;
      m_ps     <= 1'b0;
    end else begin
      m_out <= exp_out(m_cyc, m_shadow, en_out, en_pwm);
      m_ps  <= ((m_cyc + 1) % PER == 0);
      if ((m_cyc + 1) % PER == 0) m_shadow <= duty;
      m_cyc <= m_cyc + 1;
    end
  end

  task automatic wait_ps(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < int'(PER) + 16; i++) begin
      @(negedge clk);
      if (period_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (out !== 16'h0000) $display("FAIL reset_out: out=%h required 0000", out);
      else n_pass++;
      n_checks++;
      if (period_start !== 1'b0) $display("FAIL reset_ps: period_start=%b required 0", period_start);
      else n_pass++;
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (dut.pwm_cnt !== 8'h00) $display("FAIL reset_pwm_cnt: pwm_cnt=%h required 00", dut.pwm_cnt);
    else n_pass++;
    n_checks++;
    if (dut.u_timebase.pre_cnt_q !== '0)
      $display("FAIL reset_pre_cnt: pre_cnt=%0d required 0", dut.u_timebase.pre_cnt_q);
    else n_pass++;
    repeat (P - 1) @(negedge clk);
    n_checks++;
    if (dut.pwm_cnt !== 8'h00) $display("FAIL cnt_hold: pwm_cnt=%h required 00", dut.pwm_cnt);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (dut.pwm_cnt !== 8'h01) $display("FAIL cnt_first_tick: pwm_cnt=%h required 01", dut.pwm_cnt);
    else n_pass++;
    n_checks++;
    if (out !== m_out) $display("FAIL reset_model: out=%h required %h", out, m_out);
    else n_pass++;
  endtask

  task automatic test_static();
    @(negedge clk);
    en_pwm = 16'h0000;
    en_out = 16'h0001;
    #1;
    n_checks++;
    if (out !== 16'h0000) $display("FAIL static_early: out=%h required 0000", out);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (out !== 16'h0001) $display("FAIL static_ch0: out=%h required 0001", out);
    else n_pass++;
    @(negedge clk);
    en_out = 16'h8000;
    #1;
    n_checks++;
    if (out !== 16'h0001) $display("FAIL static_hold: out=%h required 0001", out);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (out !== 16'h8000) $display("FAIL static_ch15: out=%h required 8000", out);
    else n_pass++;
  endtask

  task automatic test_pwm50();
    bit ok;
    int hi = 0, lo = 0, ps_at = -1, mism = 0, f_k = 0;
    logic [15:0] o1 = 16'h0, f_out = 16'h0, f_exp = 16'h0;
    en_out = 16'hFFFF;
    en_pwm = 16'hFFFF;
    duty   = 8'h80;
    wait_ps(ok);
    n_checks++;
    if (!ok) $display("FAIL pwm50_wait: period_start seen=%b required 1", ok);
    else n_pass++;
    for (int k = 1; k <= int'(PER); k++) begin
      @(negedge clk);
      if (k == 1) o1 = out;
      if (out == 16'hFFFF) hi++;
      else if (out == 16'h0000) lo++;
      if (period_start && ps_at < 0) ps_at = k;
      if (out !== m_out || period_start !== m_ps) begin
        if (mism == 0) begin f_k = k; f_out = out; f_exp = m_out; end
        mism++;
      end
    end
    n_checks++;
    if (o1 !== 16'hFFFF) $display("FAIL pwm50_rise: out=%h required FFFF", o1);
    else n_pass++;
    n_checks++;
    if (hi != 1664) $display("FAIL pwm50_high: high clk=%0d required 1664", hi);
    else n_pass++;
    n_checks++;
    if (lo != 1664) $display("FAIL pwm50_low: low clk=%0d required 1664", lo);
    else n_pass++;
    n_checks++;
    if (ps_at != int'(PER)) $display("FAIL pwm50_period: spacing=%0d required %0d", ps_at, PER);
    else n_pass++;
    n_checks++;
    if (mism != 0)
      $display("FAIL pwm50_model: %0d cycles differ (first k=%0d out=%h want %h), required 0",
               mism, f_k, f_out, f_exp);
    else n_pass++;
  endtask

  task automatic test_extremes();
    bit ok;
    int nz = 0, dip = 0, ps_at = -1;
    duty = 8'h00;
    wait_ps(ok);
    n_checks++;
    if (!ok) $display("FAIL zero_wait: period_start seen=%b required 1", ok);
    else n_pass++;
    for (int k = 1; k <= 2 * int'(PER); k++) begin
      @(negedge clk);
      if (out !== 16'h0000) nz++;
    end
    n_checks++;
    if (nz != 0) $display("FAIL duty_zero: non-zero clk=%0d required 0", nz);
    else n_pass++;
    duty = 8'hFF;
    wait_ps(ok);
    n_checks++;
    if (!ok) $display("FAIL full_wait: period_start seen=%b required 1", ok);
    else n_pass++;
    for (int k = 1; k <= int'(PER) + 20; k++) begin
      @(negedge clk);
      if (out !== 16'hFFFF) dip++;
      if (period_start && ps_at < 0) ps_at = k;
    end
    n_checks++;
    if (dip != 0) $display("FAIL duty_full: dip clk=%0d required 0", dip);
    else n_pass++;
    n_checks++;
    if (ps_at != int'(PER)) $display("FAIL full_period: spacing=%0d required %0d", ps_at, PER);
    else n_pass++;
  endtask

  task automatic test_shadow();
    bit ok;
    int hi0 = 0, hi1 = 0;
    duty = 8'h40;
    wait_ps(ok);
    n_checks++;
    if (!ok) $display("FAIL shadow_wait: period_start seen=%b required 1", ok);
    else n_pass++;
    for (int k = 1; k <= 2 * int'(PER); k++) begin
      @(negedge clk);
      if (out == 16'hFFFF) begin
        if (k <= int'(PER)) hi0++;
        else hi1++;
      end
      if (k == 32 * int'(P)) duty = 8'hC0;
    end
    n_checks++;
    if (hi0 != 832) $display("FAIL shadow_current: high clk=%0d required 832", hi0);
    else n_pass++;
    n_checks++;
    if (hi1 != 2496) $display("FAIL shadow_next: high clk=%0d required 2496", hi1);
    else n_pass++;
  endtask

  task automatic test_mixed_reset();
    bit ok;
    int mism = 0, f_k = 0, ps_at = -1, bad_static = 0, bad_first = 0, hi_pwm = 0;
    logic [15:0] f_out = 16'h0, f_exp = 16'h0;
    en_out = 16'hFFFF;
    en_pwm = 16'h00FF;
    duty   = 8'h40;
    wait_ps(ok);
    n_checks++;
    if (!ok) $display("FAIL mixed_wait: period_start seen=%b required 1", ok);
    else n_pass++;
    for (int k = 1; k <= 16 * int'(P); k++) begin
      @(negedge clk);
      if (out !== m_out || period_start !== m_ps) begin
        if (mism == 0) begin f_k = k; f_out = out; f_exp = m_out; end
        mism++;
      end
    end
    n_checks++;
    if (out !== 16'hFFFF) $display("FAIL mixed_high: out=%h required FFFF", out);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out !== 16'h0000) $display("FAIL async_reset: out=%h required 0000", out);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= int'(PER) + 64 * int'(P) + 8; k++) begin
      @(negedge clk);
      if (out[15:8] !== 8'hFF) bad_static++;
      if (k <= int'(PER) && out[7:0] !== 8'h00) bad_first++;
      if (k > int'(PER) && out[7:0] == 8'hFF) hi_pwm++;
      if (period_start && ps_at < 0) ps_at = k;
      if (out !== m_out || period_start !== m_ps) begin
        if (mism == 0) begin f_k = k; f_out = out; f_exp = m_out; end
        mism++;
      end
    end
    n_checks++;
    if (ps_at != int'(PER)) $display("FAIL restart_period: first pulse=%0d required %0d", ps_at, PER);
    else n_pass++;
    n_checks++;
    if (bad_static != 0) $display("FAIL mixed_static: bad clk=%0d required 0", bad_static);
    else n_pass++;
    n_checks++;
    if (bad_first != 0) $display("FAIL restart_duty0: bad clk=%0d required 0", bad_first);
    else n_pass++;
    n_checks++;
    if (hi_pwm != 832) $display("FAIL restart_high: high clk=%0d required 832", hi_pwm);
    else n_pass++;
    n_checks++;
    if (mism != 0)
      $display("FAIL mixed_model: %0d cycles differ (first k=%0d out=%h want %h), required 0",
               mism, f_k, f_out, f_exp);
    else n_pass++;
  endtask

  task automatic test_random();
    int mism = 0, f_k = 0;
    logic [15:0] f_out = 16'h0, f_exp = 16'h0;
    int unsigned r;
    for (int k = 1; k <= 2 * int'(PER); k++) begin
      @(negedge clk);
      if (out !== m_out || period_start !== m_ps) begin
        if (mism == 0) begin f_k = k; f_out = out; f_exp = m_out; end
        mism++;
      end
      // Occasionally change everything in the very cycle a period boundary is taken.
      if ($urandom_range(0, 199) == 0 || ((m_cyc + 1) % PER == 0)) begin
        r = $urandom_range(0, 9);
        duty = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 299) == 0 || ((m_cyc + 1) % PER == 0)) begin
        en_out = 16'($urandom);
        en_pwm = 16'($urandom);
      end
    end
    n_checks++;
    if (mism != 0)
      $display("FAIL random_model: %0d cycles differ (first k=%0d out=%h want %h), required 0",
               mism, f_k, f_out, f_exp);
    else n_pass++;
  endtask

  initial begin
    rst_n  = 1'b0;
    en_out = 16'hFFFF;
    en_pwm = 16'hFFFF;
    duty   = 8'hFF;
    test_reset();
    test_static();
    test_pwm50();
    test_extremes();
    test_shadow();
    test_mixed_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
